// File: rtl/regfile_pkg.sv
// Shared types and limits for the multi-port register file (regfile_mp).
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int MAX_READ  = 8;
    localparam int MAX_WRITE = 4;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks addresses 1..REG_COUNT-1 writing zero, then raises ready.
//   state | meaning
//   CLEAR | zeroing ram[clr_addr] each edge; external writes blocked, reads return 0
//   RUN   | array usable, ready=1
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int REG_COUNT  = 32,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr,
    output logic                  ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REG_COUNT - 1);

    rf_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= ADDR_WIDTH'(1);
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // The counter stops at LAST_ADDR, so non-power-of-two REG_COUNT never wraps.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = RUN;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                end
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    assign clear_we   = (state_q == CLEAR) && !rst;
    assign clear_addr = clr_addr_q;
    assign ready      = (state_q == RUN);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file, x0 hardwired to zero, self-clearing after reset.
// Optional write-first read bypass when REGFILE_MP_BYPASS_EN is defined.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_COUNT  = 32,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT),
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            ready,
    input  logic [NUM_READ-1:0]             rs_en,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  rs_addr,
    output logic [NUM_READ*WIDTH-1:0]       rs_data,
    input  logic [NUM_WRITE-1:0]            wr_en,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WRITE*WIDTH-1:0]      wr_data
);

    if (NUM_READ < 1 || NUM_READ > MAX_READ) begin : g_bad_read
        $error("regfile_mp: NUM_READ out of range");
    end
    if (NUM_WRITE < 1 || NUM_WRITE > MAX_WRITE) begin : g_bad_write
        $error("regfile_mp: NUM_WRITE out of range");
    end
    if (REG_COUNT < 2) begin : g_bad_count
        $error("regfile_mp: REG_COUNT must be at least 2");
    end

    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic [WIDTH-1:0]      ram_q [REG_COUNT-1:1];

    regfile_clear_seq #(
        .REG_COUNT  (REG_COUNT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .ready      (ready)
    );

    // Ascending loop: a later (higher-indexed) port overrides a lower one on collision.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            ram_q[clear_addr] <= '0;
        end else if (ready && !rst) begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wr_en[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
                    ram_q[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[w*WIDTH +: WIDTH];
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      rd_data;

        assign addr = rs_addr[r*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd_data = '0;
            if (ready && rs_en[r] && (addr != '0)) begin
                rd_data = ram_q[addr];
`ifdef REGFILE_MP_BYPASS_EN
                for (int w = 0; w < NUM_WRITE; w++) begin
                    if (wr_en[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == addr)) begin
                        rd_data = wr_data[w*WIDTH +: WIDTH];
                    end
                end
`endif
            end
        end

        assign rs_data[r*WIDTH +: WIDTH] = rd_data;
    end

endmodule
